clk_switch_ctrl: RTL and testbench

CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

---
 rtl/clk_sw_pkg.sv | 24 ++
 rtl/clk_switch_ctrl_if.sv | 30 +++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/clk_switch_ctrl.sv | 150 +++++++++++++++
 tb/tb_clk_switch_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/clk_sw_pkg.sv
// ============================================================================
//  Module      : clk_sw_pkg
//  Description : Shared types and constants for the clock-switch controller:
//                FSM state encoding and clock-source identifiers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_sw_pkg;

   // Clock-source identifiers as seen on sel / cur_src
   localparam logic SRC_CLK_1 = 1'b0;
   localparam logic SRC_CLK_2 = 1'b1;

   // Controller state encoding
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DWELL  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/clk_switch_ctrl_if.sv
// ============================================================================
//  Module      : clk_switch_ctrl_if
//  Description : Requester-side bundle of the clock-switch controller.
//                master = requesters / environment, slave = controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface clk_switch_ctrl_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] req_tgt;
   logic [N_REQ-1:0] ack;
   logic             sel;
   logic             cur_src;
   logic             busy;

   modport master (
      output req, req_tgt,
      input  ack, sel, cur_src, busy
   );

   modport slave (
      input  req, req_tgt,
      output ack, sel, cur_src, busy
   );
endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Chooses the first
//                eligible (requesting and unmasked) index at or after the
//                pointer, wrapping modulo N_REQ. One-hot grant plus valid.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [N_REQ-1:0] i_mask,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_gnt,
   output logic             o_valid
);

   logic [N_REQ-1:0] w_elig;

   assign w_elig = i_req & ~i_mask;

   // Scan distances 0..N_REQ-1 from the pointer; the first eligible index wins
   always_comb begin
      o_gnt   = '0;
      o_valid = 1'b0;
      for (int j = 0; j < N_REQ; j++) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!o_valid && w_elig[i] &&
                (((i + N_REQ - int'(i_ptr)) % N_REQ) == j)) begin
               o_gnt[i] = 1'b1;
               o_valid  = 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/clk_switch_ctrl.sv
// ============================================================================
//  Module      : clk_switch_ctrl
//  Description : Arbitrates clock-source change requests from N_REQ
//                requesters, drives the glitch-free mux select, waits
//                SETTLE_CYCLES before committing the new source and acking.
//                Optional macro CLK_SWITCH_CTRL_DWELL_EN adds a DWELL state
//                that holds busy for DWELL_CYCLES after each committed switch.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_switch_ctrl
   import clk_sw_pkg::*;
#(
   parameter int N_REQ         = 4,
   parameter int SETTLE_CYCLES = 8,
   parameter int DWELL_CYCLES  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   clk_switch_ctrl_if.slave     if_bus
);

   localparam int c_PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int c_CNT_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
   localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

   state_t             r_state,   w_state_nxt;
   logic               r_sel,     w_sel_nxt;
   logic               r_cur_src, w_cur_nxt;
   logic [N_REQ-1:0]   r_ack,     w_ack_nxt;
   logic               r_busy,    w_busy_nxt;
   logic [c_CNT_W-1:0] r_cnt,     w_cnt_nxt;
   logic [c_PTR_W-1:0] r_ptr,     w_ptr_nxt;
   logic [c_PTR_W-1:0] r_gidx,    w_gidx_nxt;

   logic [N_REQ-1:0]   w_gnt;
   logic               w_gnt_valid;
   logic [c_PTR_W-1:0] w_gidx;

   // The requester being acked this cycle still holds req; mask it out
   rr_arbiter #(
      .N_REQ (N_REQ),
      .PTR_W (c_PTR_W)
   ) u_arb (
      .i_req   (if_bus.req),
      .i_mask  (r_ack),
      .i_ptr   (r_ptr),
      .o_gnt   (w_gnt),
      .o_valid (w_gnt_valid)
   );

   // One-hot grant to binary index
   always_comb begin
      w_gidx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_gnt[i]) w_gidx = c_PTR_W'(i);
      end
   end

   // State and output registers; reset aborts any switch in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_sel     <= SRC_CLK_1;
         r_cur_src <= SRC_CLK_1;
         r_ack     <= '0;
         r_busy    <= 1'b0;
         r_cnt     <= '0;
         r_ptr     <= '0;
         r_gidx    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_sel     <= w_sel_nxt;
         r_cur_src <= w_cur_nxt;
         r_ack     <= w_ack_nxt;
         r_busy    <= w_busy_nxt;
         r_cnt     <= w_cnt_nxt;
         r_ptr     <= w_ptr_nxt;
         r_gidx    <= w_gidx_nxt;
      end
   end

   // Next-state: grant only in IDLE, count down settle (and dwell), ack on commit
   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_cur_nxt   = r_cur_src;
      w_ack_nxt   = '0;
      w_busy_nxt  = r_busy;
      w_cnt_nxt   = r_cnt;
      w_ptr_nxt   = r_ptr;
      w_gidx_nxt  = r_gidx;
      case (r_state)
         ST_IDLE: begin
            if (w_gnt_valid) begin
               w_ptr_nxt = (w_gidx == c_PTR_W'(N_REQ - 1)) ? '0 : w_gidx + c_PTR_W'(1);
               if (if_bus.req_tgt[w_gidx] == r_cur_src) begin
                  // Already on the requested source: acknowledge immediately
                  w_ack_nxt = w_gnt;
               end else begin
                  w_sel_nxt   = if_bus.req_tgt[w_gidx];
                  w_state_nxt = ST_SETTLE;
                  w_busy_nxt  = 1'b1;
                  w_cnt_nxt   = c_CNT_W'(SETTLE_CYCLES - 1);
                  w_gidx_nxt  = w_gidx;
               end
            end
         end
         ST_SETTLE: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - c_CNT_W'(1);
            end else begin
               // Commit regardless of whether the requester still holds req
               w_cur_nxt         = r_sel;
               w_ack_nxt[r_gidx] = 1'b1;
`ifdef CLK_SWITCH_CTRL_DWELL_EN
               w_state_nxt = ST_DWELL;
               w_cnt_nxt   = c_CNT_W'(DWELL_CYCLES - 1);
`else
               w_state_nxt = ST_IDLE;
               w_busy_nxt  = 1'b0;
`endif
            end
         end
`ifdef CLK_SWITCH_CTRL_DWELL_EN
         ST_DWELL: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - c_CNT_W'(1);
            end else begin
               w_state_nxt = ST_IDLE;
               w_busy_nxt  = 1'b0;
            end
         end
`endif
         default: begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   assign if_bus.ack     = r_ack;
   assign if_bus.sel     = r_sel;
   assign if_bus.cur_src = r_cur_src;
   assign if_bus.busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_clk_switch_ctrl.sv
// ============================================================================
//  Module      : tb_clk_switch_ctrl
//  Description : Self-checking bench for clk_switch_ctrl: table of same-source
//                arbitration vectors plus directed switch sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_switch_ctrl;

   localparam int N  = 4;
   localparam int S  = 8;
   localparam int D  = 16;
`ifdef CLK_SWITCH_CTRL_DWELL_EN
   localparam int D_GAP = D;
`else
   localparam int D_GAP = 0;
`endif

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   clk_switch_ctrl_if #(.N_REQ(N)) u_if ();

   clk_switch_ctrl #(
      .N_REQ         (N),
      .SETTLE_CYCLES (S),
      .DWELL_CYCLES  (D)
   ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .if_bus (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] req;
      logic [N-1:0] tgt;
      logic [N-1:0] exp_ack;
   } vec_t;

   vec_t vecs [13];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      u_if.req = '0;
      u_if.req_tgt = '0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
   endtask

   // Full switch timeline for one requester; drop_at>0 drops req that many cycles into settle
   task automatic run_switch(input int idx, input logic tgt, input int drop_at);
      u_if.req_tgt[idx] = tgt;
      u_if.req[idx]     = 1'b1;
      step();
      check($sformatf("sw%0d_grant_sel", idx), 32'(u_if.sel), 32'(tgt));
      check($sformatf("sw%0d_grant_busy", idx), 32'(u_if.busy), 32'(1));
      check($sformatf("sw%0d_grant_ack", idx), 32'(u_if.ack), 32'(0));
      for (int c = 1; c < S; c++) begin
         step();
         check($sformatf("sw%0d_settle%0d_ack", idx, c), 32'(u_if.ack), 32'(0));
         check($sformatf("sw%0d_settle%0d_cur", idx, c), 32'(u_if.cur_src), 32'(!tgt));
         if (c == drop_at) u_if.req[idx] = 1'b0;
      end
      step();
      check($sformatf("sw%0d_commit_ack", idx), 32'(u_if.ack), 32'(1) << idx);
      check($sformatf("sw%0d_commit_cur", idx), 32'(u_if.cur_src), 32'(tgt));
      check($sformatf("sw%0d_commit_busy", idx), 32'(u_if.busy), 32'(D_GAP > 0));
      for (int j = 1; j <= D_GAP + 1; j++) begin
         step();
         check($sformatf("sw%0d_post%0d_ack", idx, j), 32'(u_if.ack), 32'(0));
         check($sformatf("sw%0d_post%0d_busy", idx, j), 32'(u_if.busy), 32'(j < D_GAP));
         if (j == 1) u_if.req[idx] = 1'b0;
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      u_if.req = '0;
      u_if.req_tgt = '0;

      // Same-source round-robin vectors, cur_src=0, pointer starts at 0
      vecs[0]  = '{4'b0000, 4'b0000, 4'b0000};
      vecs[1]  = '{4'b0001, 4'b0000, 4'b0001};
      vecs[2]  = '{4'b0001, 4'b0000, 4'b0000};
      vecs[3]  = '{4'b0000, 4'b0000, 4'b0000};
      vecs[4]  = '{4'b1010, 4'b0000, 4'b0010};
      vecs[5]  = '{4'b1010, 4'b0000, 4'b1000};
      vecs[6]  = '{4'b1000, 4'b0000, 4'b0000};
      vecs[7]  = '{4'b0101, 4'b0000, 4'b0001};
      vecs[8]  = '{4'b0101, 4'b0000, 4'b0100};
      vecs[9]  = '{4'b0100, 4'b0000, 4'b0000};
      vecs[10] = '{4'b1001, 4'b0000, 4'b1000};
      vecs[11] = '{4'b0001, 4'b0000, 4'b0001};
      vecs[12] = '{4'b0000, 4'b0000, 4'b0000};

      #2;
      check("rst_async_sel", 32'(u_if.sel), 32'(0));
      check("rst_async_ack", 32'(u_if.ack), 32'(0));
      do_reset();
      check("rst_sel", 32'(u_if.sel), 32'(0));
      check("rst_cur", 32'(u_if.cur_src), 32'(0));
      check("rst_busy", 32'(u_if.busy), 32'(0));
      check("rst_ack", 32'(u_if.ack), 32'(0));

      for (int i = 0; i < 13; i++) begin
         u_if.req     = vecs[i].req;
         u_if.req_tgt = vecs[i].tgt;
         step();
         check($sformatf("vec%0d_ack", i), 32'(u_if.ack), 32'(vecs[i].exp_ack));
         check($sformatf("vec%0d_sel", i), 32'(u_if.sel), 32'(0));
         check($sformatf("vec%0d_busy", i), 32'(u_if.busy), 32'(0));
      end
      u_if.req = '0;
      step();

      // Switch to clk_2 by requester 1, then back by requester 2 dropping req mid-settle
      run_switch(1, 1'b1, -1);
      run_switch(2, 1'b0, 3);

      // Reset three cycles into settle aborts the switch
      do_reset();
      u_if.req_tgt[1] = 1'b1;
      u_if.req[1]     = 1'b1;
      step();
      check("abort_grant_sel", 32'(u_if.sel), 32'(1));
      repeat (3) step();
      rst_n = 1'b0;
      u_if.req = '0;
      #1;
      check("abort_sel", 32'(u_if.sel), 32'(0));
      check("abort_cur", 32'(u_if.cur_src), 32'(0));
      check("abort_busy", 32'(u_if.busy), 32'(0));
      for (int c = 0; c < S + 2; c++) begin
         step();
         check($sformatf("abort_hold%0d_ack", c), 32'(u_if.ack), 32'(0));
      end
      rst_n = 1'b1;
      step();
      check("abort_rel_sel", 32'(u_if.sel), 32'(0));
      check("abort_rel_busy", 32'(u_if.busy), 32'(0));
      run_switch(2, 1'b1, -1);

      // Four simultaneous requests with alternating targets
      begin
         int           acks_seen;
         int           sel_cnt;
         int           ack_cyc [4];
         int           ack_id  [4];
         int           sel_cyc [4];
         logic         prev_sel;
         logic [N-1:0] pend;
         acks_seen = 0;
         sel_cnt   = 0;
         pend      = '0;
         do_reset();
         u_if.req_tgt = 4'b0101;
         u_if.req     = 4'b1111;
         prev_sel     = u_if.sel;
         for (int cyc = 1; cyc <= 4 * (S + D + 2) + 10; cyc++) begin
            step();
            if (u_if.sel !== prev_sel) begin
               if (sel_cnt < 4) sel_cyc[sel_cnt] = cyc;
               sel_cnt++;
               prev_sel = u_if.sel;
            end
            if (u_if.ack != '0) begin
               check($sformatf("rr_onehot_c%0d", cyc), 32'($countones(u_if.ack)), 32'(1));
               if (acks_seen < 4) begin
                  ack_cyc[acks_seen] = cyc;
                  for (int b = 0; b < N; b++) if (u_if.ack[b]) ack_id[acks_seen] = b;
               end
               acks_seen++;
            end
            u_if.req = u_if.req & ~pend;
            pend     = u_if.ack;
         end
         check("rr_ack_count", 32'(acks_seen), 32'(4));
         check("rr_switch_count", 32'(sel_cnt), 32'(4));
         check("rr_final_cur", 32'(u_if.cur_src), 32'(0));
         if (acks_seen == 4 && sel_cnt == 4) begin
            for (int n = 0; n < 4; n++) begin
               check($sformatf("rr_order%0d", n), 32'(ack_id[n]), 32'(n));
               check($sformatf("rr_settle%0d", n), 32'(ack_cyc[n]), 32'(sel_cyc[n] + S));
               if (n > 0)
                  check($sformatf("rr_gap%0d", n), 32'(sel_cyc[n]), 32'(ack_cyc[n-1] + 1 + D_GAP));
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
